// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder: default geometry and the
// per-stage register record carried down the pipeline.
package pipelined_adder_pkg;

   // Default operand width and pipeline depth for the top level.
   localparam int PA_DEFAULT_WIDTH  = 32;
   localparam int PA_DEFAULT_STAGES = 4;

   // Widest operand the stage record can carry; WIDTH must not exceed it.
   localparam int PA_MAX_WIDTH      = 64;

   // One pipeline stage: valid flag, carry out of the chunk just added,
   // partial sum (chunks 0..k filled in), and the full effective operands
   // so that later stages can pick up their own chunks.
   typedef struct packed {
      logic                    valid;
      logic                    carry;
      logic [PA_MAX_WIDTH-1:0] sum;
      logic [PA_MAX_WIDTH-1:0] op_a;
      logic [PA_MAX_WIDTH-1:0] op_b;
   } pa_stage_t;

endpackage

// File: rtl/pipelined_adder_chunk.sv
// CHUNK-bit combinational ripple-carry adder slice used once per pipeline
// stage of pipelined_adder.
module adder_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cy_in,
   output logic [CHUNK-1:0] sum,
   output logic             cy_out
);

   // Ripple the carry bit by bit through the slice.
   always_comb begin
      logic carry;
      carry = cy_in;
      sum   = '0;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cy_out = carry;
   end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit with valid/ready handshakes on both sides.
// Stage k adds operand chunk k using the registered carry of stage k-1;
// results leave in acceptance order, STAGES cycles after acceptance.
// Optional signed-overflow output: define PIPELINED_ADDER_OVF_EN.
// WIDTH must be a multiple of STAGES and no larger than PA_MAX_WIDTH.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = PA_DEFAULT_WIDTH,
   parameter int STAGES = PA_DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cy_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cy_out,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   pa_stage_t stage_q [STAGES];
   pa_stage_t stage_d [STAGES];

   logic [STAGES-1:0]            valid_v;
   logic [STAGES-1:0]            load_ok;
   logic [STAGES-1:0][CHUNK-1:0] ca;
   logic [STAGES-1:0][CHUNK-1:0] cb;
   logic [STAGES-1:0][CHUNK-1:0] cs;
   logic [STAGES-1:0]            ci;
   logic [STAGES-1:0]            co;

   logic             rdy_q;
   logic             in_fire;
   logic [WIDTH-1:0] b_eff;
   logic             cy_eff;

   // Subtraction is A + ~B + 1; carry-in is ignored in that mode.
   assign b_eff  = sub ? ~b : b;
   assign cy_eff = sub | cy_in;

   // Gather stage valid bits into one vector for the ready computation.
   always_comb begin
      valid_v = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         valid_v[k] = stage_q[k].valid;
      end
   end

   // Chunk adders and per-stage load enables.
   // A stage may load when some stage at or after it is empty, or the
   // output is draining: the recursive "empty or advancing" rule unrolled,
   // so no enable depends on another enable bit.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign ca[k] = a[CHUNK-1:0];
         assign cb[k] = b_eff[CHUNK-1:0];
         assign ci[k] = cy_eff;
      end else begin : g_body
         assign ca[k] = stage_q[k-1].op_a[k*CHUNK +: CHUNK];
         assign cb[k] = stage_q[k-1].op_b[k*CHUNK +: CHUNK];
         assign ci[k] = stage_q[k-1].carry;
      end

      adder_chunk #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a      (ca[k]),
         .b      (cb[k]),
         .cy_in  (ci[k]),
         .sum    (cs[k]),
         .cy_out (co[k])
      );

      assign load_ok[k] = out_ready | ~(&valid_v[STAGES-1:k]);
   end

   // No beat is taken until the first clock edge after reset release.
   assign in_ready = rdy_q & load_ok[0];
   assign in_fire  = in_valid & in_ready;

   // Next contents of each stage: the upstream record with this stage's
   // chunk sum and carry merged in.
   always_comb begin
      stage_d[0]                  = '0;
      stage_d[0].valid            = in_fire;
      stage_d[0].carry            = co[0];
      stage_d[0].sum[CHUNK-1:0]   = cs[0];
      stage_d[0].op_a[WIDTH-1:0]  = a;
      stage_d[0].op_b[WIDTH-1:0]  = b_eff;
      for (int unsigned k = 1; k < STAGES; k++) begin
         stage_d[k]                         = stage_q[k-1];
         stage_d[k].carry                   = co[k];
         stage_d[k].sum[k*CHUNK +: CHUNK]   = cs[k];
      end
   end

   // Stage registers: a bubble only clears the valid bit so the last
   // result's data stays put on the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         rdy_q <= 1'b1;
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (load_ok[k]) begin
               if (stage_d[k].valid) begin
                  stage_q[k] <= stage_d[k];
               end else begin
                  stage_q[k].valid <= 1'b0;
               end
            end
         end
      end
   end

   assign out_valid = stage_q[LAST].valid;
   assign sum       = stage_q[LAST].sum[WIDTH-1:0];
   assign cy_out    = stage_q[LAST].carry;

`ifdef PIPELINED_ADDER_OVF_EN
   logic ovf_d;
   logic ovf_q;

   // Carry-into-MSB XOR carry-out-of-MSB, expressed through operand and
   // result sign bits so the chunk adder needs no extra tap.
   always_comb begin
      ovf_d = (stage_d[LAST].op_a[WIDTH-1] ~^ stage_d[LAST].op_b[WIDTH-1]) &
              (stage_d[LAST].sum[WIDTH-1] ^ stage_d[LAST].op_a[WIDTH-1]);
   end

   // Overflow flag travels with the result into the last stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (load_ok[LAST] && stage_d[LAST].valid) begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=8, STAGES=4).
// Expected overflow honours PIPELINED_ADDER_OVF_EN.
module tb_pipelined_adder;

   localparam int W = 8;
   localparam int S = 4;
`ifdef PIPELINED_ADDER_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } res_t;

   logic         clk, rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] a, b, sum;
   logic         cy_in, sub, cy_out, ovf;

   int n_chk  = 0;
   int n_pass = 0;
   res_t exp_q[$];

   pipelined_adder #(
      .WIDTH  (W),
      .STAGES (S)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cy_in     (cy_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cy_out    (cy_out),
      .ovf       (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Arithmetic reference: unsigned result for sum/carry, signed range for overflow.
   function automatic res_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic ci, input logic sb);
      res_t r;
      int   full, sres, sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      if (sb) begin
         full = int'(x) - int'(y) + 256;
         sres = sx - sy;
      end else begin
         full = int'(x) + int'(y) + int'(ci);
         sres = sx + sy + int'(ci);
      end
      r.s = full[W-1:0];
      r.c = full[W];
      r.v = OVF_ON & ((sres > 127) || (sres < -128));
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive_rand(input logic v);
      a        = W'($urandom_range(0, 255));
      b        = W'($urandom_range(0, 255));
      cy_in    = 1'($urandom_range(0, 1));
      sub      = 1'($urandom_range(0, 1));
      in_valid = v;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cy_in = 1'b0; sub = 1'b0;
      repeat (2) tick();
      mid();
      n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
      n_chk++; if (sum !== 8'h00) $display("FAIL reset_sum: got %h want 00", sum); else n_pass++;
      n_chk++; if (cy_out !== 1'b0) $display("FAIL reset_cy_out: got %b want 0", cy_out); else n_pass++;
      n_chk++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
      n_chk++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
      rst_n = 1'b1;
      #1;
      n_chk++; if (in_ready !== 1'b0) $display("FAIL release_in_ready_pre_edge: got %b want 0", in_ready); else n_pass++;
      tick();
      n_chk++; if (in_ready !== 1'b1) $display("FAIL release_in_ready_post_edge: got %b want 1", in_ready); else n_pass++;
   endtask

   task automatic test_directed();
      logic [W-1:0] da[3], db[3], ds[3];
      logic         dci[3], dsb[3], dc[3], dv[3];
      int           lat;
      logic [W+1:0] got;
      da  = '{8'hFF, 8'h05, 8'h7F};
      db  = '{8'h01, 8'h07, 8'h01};
      dci = '{1'b0, 1'b0, 1'b0};
      dsb = '{1'b0, 1'b1, 1'b0};
      ds  = '{8'h00, 8'hFE, 8'h80};
      dc  = '{1'b1, 1'b0, 1'b0};
      dv  = '{1'b0, 1'b0, OVF_ON};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = da[i]; b = db[i]; cy_in = dci[i]; sub = dsb[i]; in_valid = 1'b1;
         mid();
         n_chk++; if (in_ready !== 1'b1) $display("FAIL directed%0d_in_ready: got %b want 1", i, in_ready); else n_pass++;
         tick();
         in_valid = 1'b0;
         lat = 0; got = '0;
         for (int n = 1; n <= 8; n++) begin
            mid();
            if (lat == 0 && out_valid === 1'b1) begin
               lat = n; got = {sum, cy_out, ovf};
            end
            tick();
         end
         n_chk++; if (lat != S) $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, S); else n_pass++;
         n_chk++;
         if (got !== {ds[i], dc[i], dv[i]})
            $display("FAIL directed%0d_result: got sum=%h cy=%b ovf=%b want sum=%h cy=%b ovf=%b",
                     i, got[W+1:2], got[1], got[0], ds[i], dc[i], dv[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int   sent, got, first_cyc, last_cyc, gaps, ready_drop;
      res_t e;
      sent = 0; got = 0; first_cyc = -1; last_cyc = -1; gaps = 0; ready_drop = 0;
      exp_q.delete();
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
         if (sent < 10) drive_rand(1'b1); else in_valid = 1'b0;
         mid();
         if (out_valid === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               $display("FAIL b2b_unexpected: got sum=%h with no beat outstanding", sum);
            end else begin
               e = exp_q.pop_front();
               if ({sum, cy_out, ovf} !== e)
                  $display("FAIL b2b_result%0d: got %h/%b/%b want %h/%b/%b", got, sum, cy_out, ovf, e.s, e.c, e.v);
               else n_pass++;
            end
            if (got == 0) first_cyc = cyc;
            else if (cyc != last_cyc + 1) gaps++;
            last_cyc = cyc;
            got++;
         end
         if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(ref_model(a, b, cy_in, sub));
            sent++;
         end else if (in_valid) begin
            ready_drop++;
         end
         tick();
      end
      in_valid = 1'b0;
      n_chk++; if (got != 10) $display("FAIL b2b_count: got %0d want 10", got); else n_pass++;
      n_chk++; if (first_cyc != S) $display("FAIL b2b_first_cycle: got %0d want %0d", first_cyc, S); else n_pass++;
      n_chk++; if (gaps != 0) $display("FAIL b2b_consecutive: got %0d gaps want 0", gaps); else n_pass++;
      n_chk++; if (ready_drop != 0) $display("FAIL b2b_in_ready: got %0d stalls want 0", ready_drop); else n_pass++;
   endtask

   task automatic test_stall();
      int           acc, unstable, have, got, gaps, last_cyc;
      logic [W+1:0] hold;
      res_t         e;
      acc = 0; unstable = 0; have = 0; hold = '0;
      exp_q.delete();
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         drive_rand(1'b1);
         mid();
         if (have != 0) begin
            if (out_valid !== 1'b1 || {sum, cy_out, ovf} !== hold) unstable++;
         end else if (out_valid === 1'b1) begin
            have = 1; hold = {sum, cy_out, ovf};
         end
         if (in_ready === 1'b1) begin
            exp_q.push_back(ref_model(a, b, cy_in, sub));
            acc++;
         end
         tick();
      end
      mid();
      n_chk++; if (acc != S) $display("FAIL stall_accepted: got %0d want %0d", acc, S); else n_pass++;
      n_chk++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else n_pass++;
      n_chk++; if (unstable != 0 || have == 0) $display("FAIL stall_hold: got %0d changes (seen=%0d) want 0", unstable, have); else n_pass++;
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      got = 0; gaps = 0; last_cyc = -1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         mid();
         if (out_valid === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               $display("FAIL drain_unexpected: got sum=%h with no beat outstanding", sum);
            end else begin
               e = exp_q.pop_front();
               if ({sum, cy_out, ovf} !== e)
                  $display("FAIL drain_result%0d: got %h/%b/%b want %h/%b/%b", got, sum, cy_out, ovf, e.s, e.c, e.v);
               else n_pass++;
            end
            if (got != 0 && cyc != last_cyc + 1) gaps++;
            last_cyc = cyc;
            got++;
         end
         tick();
      end
      n_chk++; if (got != S || gaps != 0) $display("FAIL drain_count: got %0d results %0d gaps want %0d/0", got, gaps, S); else n_pass++;
   endtask

   task automatic test_random_backpressure();
      int           hold_err, held, got, n;
      logic [W+1:0] hold;
      res_t         e;
      hold_err = 0; held = 0; got = 0; hold = '0;
      exp_q.delete();
      for (int cyc = 0; cyc < 80; cyc++) begin
         drive_rand(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
         out_ready = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
         mid();
         if (held != 0 && (out_valid !== 1'b1 || {sum, cy_out, ovf} !== hold)) hold_err++;
         if (out_valid === 1'b1 && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               $display("FAIL bp_unexpected: got sum=%h with no beat outstanding", sum);
            end else begin
               e = exp_q.pop_front();
               if ({sum, cy_out, ovf} !== e)
                  $display("FAIL bp_result%0d: got %h/%b/%b want %h/%b/%b", got, sum, cy_out, ovf, e.s, e.c, e.v);
               else n_pass++;
            end
            got++;
         end
         held = (out_valid === 1'b1 && !out_ready) ? 1 : 0;
         hold = {sum, cy_out, ovf};
         if (in_valid && in_ready === 1'b1) exp_q.push_back(ref_model(a, b, cy_in, sub));
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         mid();
         if (out_valid === 1'b1) begin
            n_chk++;
            e = exp_q.pop_front();
            if ({sum, cy_out, ovf} !== e)
               $display("FAIL bp_drain%0d: got %h/%b/%b want %h/%b/%b", got, sum, cy_out, ovf, e.s, e.c, e.v);
            else n_pass++;
            got++;
         end
         tick();
         n++;
      end
      mid();
      n_chk++; if (exp_q.size() != 0) $display("FAIL bp_lost: got %0d beats outstanding want 0", exp_q.size()); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_extra: got out_valid=%b after drain want 0", out_valid); else n_pass++;
      n_chk++; if (hold_err != 0) $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_err); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      int   stale, lat;
      res_t e;
      logic [W+1:0] got;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_rand(1'b1);
         tick();
      end
      in_valid = 1'b0;
      tick();
      n_chk++; if (out_valid !== 1'b1) $display("FAIL rstmid_precond: got out_valid=%b want 1", out_valid); else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else n_pass++;
      n_chk++; if ({sum, cy_out, ovf} !== 10'b0) $display("FAIL rstmid_outputs: got %h/%b/%b want 00/0/0", sum, cy_out, ovf); else n_pass++;
      n_chk++; if (in_ready !== 1'b0) $display("FAIL rstmid_in_ready: got %b want 0", in_ready); else n_pass++;
      mid();
      tick();
      mid();
      rst_n = 1'b1;
      tick();
      n_chk++; if (in_ready !== 1'b1) $display("FAIL rstmid_release_ready: got %b want 1", in_ready); else n_pass++;
      stale = 0;
      for (int n = 0; n < 6; n++) begin
         mid();
         if (out_valid !== 1'b0) stale++;
         tick();
      end
      n_chk++; if (stale != 0) $display("FAIL rstmid_stale: got %0d stale cycles want 0", stale); else n_pass++;
      drive_rand(1'b1);
      e = ref_model(a, b, cy_in, sub);
      tick();
      in_valid = 1'b0;
      lat = 0; got = '0;
      for (int n = 1; n <= 8; n++) begin
         mid();
         if (lat == 0 && out_valid === 1'b1) begin
            lat = n; got = {sum, cy_out, ovf};
         end
         tick();
      end
      n_chk++; if (lat != S) $display("FAIL rstmid_latency: got %0d want %0d", lat, S); else n_pass++;
      n_chk++; if (got !== e) $display("FAIL rstmid_result: got %h want %h", got, e); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_random_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4, pipeline depth; SHALL be >= 1 and SHALL divide WIDTH exactly (CHUNK = WIDTH/STAGES).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cy_in  input  1  carry-in (add mode only).
REQ-010 sub  input  1  0 = A+B+cy_in, 1 = A-B.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cy_out  output  1  carry-out (add) / not-borrow (sub).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Beat transfers on input when in_valid && in_ready at rising clk; on output when out_valid && out_ready.
REQ-017 Effective operation: add -> A + B + cy_in; sub -> A + ~B + 1, cy_in ignored.
REQ-018 Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] using the registered carry from stage k-1 (stage 0 uses effective carry-in); operand upper chunks travel alongside in stage registers.
REQ-019 Latency from input transfer to out_valid SHALL be exactly STAGES cycles when unstalled; throughput one beat per cycle.
REQ-020 Each stage holds a valid bit; stage k loads when it is empty or its contents move to stage k+1 (or out, for last stage) in the same cycle.
REQ-021 in_ready = stage 0 empty OR stage 0 advancing; in_ready SHALL NOT depend combinationally on in_valid.
REQ-022 out_ready low: last stage holds sum/cy_out/ovf stable; bubbles upstream still collapse; when all stages full, in_ready = 0.
REQ-023 Simultaneous input and output transfer with pipeline full SHALL be accepted without loss or duplication.
REQ-024 Results SHALL emerge in acceptance order; no beat dropped or reordered.
REQ-025 cy_out = carry out of bit WIDTH-1; ovf = carry into MSB XOR carry out of MSB.
REQ-026 Wrap-around: results are modulo 2^WIDTH; no saturation.

Reset
REQ-027 rst_n low SHALL immediately clear all stage valid bits: out_valid = 0, sum = 0, cy_out = 0, ovf = 0.
REQ-028 During reset in_ready = 0; in_ready = 1 on first clk edge after rst_n deasserts.
REQ-029 Reset mid-operation discards all in-flight beats; none appear after reset.

Configuration
REQ-030 Macro PIPELINED_ADDER_OVF_EN defined: ovf computed per REQ-025 and pipelined with the result.
REQ-031 Macro undefined: ovf port retained, tied to 0, no overflow logic or register.

Structure
REQ-032 Shared package pipelined_adder_pkg SHALL hold default WIDTH/STAGES constants and the stage-register struct type (valid, partial sum, carry, pending operand chunks).
REQ-033 Per-stage chunk arithmetic SHALL be a combinational sub-module adder_chunk (CHUNK-bit ripple adder, carry in/out), instantiated STAGES times via generate.

Verification (WIDTH=8, STAGES=4, out_ready=1 unless stated)
REQ-034 a=0xFF, b=0x01, cy_in=0, sub=0 -> 4 cycles later sum=0x00, cy_out=1, ovf=0.
REQ-035 a=0x05, b=0x07, sub=1 -> sum=0xFE, cy_out=0, ovf=0; a=0x7F, b=0x01, sub=0 -> sum=0x80, ovf=1 (0 without macro).
REQ-036 Back-to-back 10 random beats every cycle -> 10 results on consecutive cycles from cycle 4, matching reference model in order.
REQ-037 out_ready=0, in_valid=1 continuously -> exactly 4 beats accepted, then in_ready=0; sum held stable; out_ready=1 drains 4 results in order.
REQ-038 Reset asserted with 3 beats in flight -> out_valid=0 same cycle; after release no stale result, first new beat emerges after 4 cycles.
